// File: rtl/gpr_file_if.sv
// Decode/writeback/scoreboard bundle for the integer register file.
// master = pipeline side (ID/EX/WB), slave = register file.
interface gpr_file_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  // read ports (ID)
  logic [AW-1:0]   rf_raddr1;
  logic [XLEN-1:0] rf_rdata1;
  logic [AW-1:0]   rf_raddr2;
  logic [XLEN-1:0] rf_rdata2;
  // writeback (WB)
  logic            wb_we;
  logic [AW-1:0]   wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  // decode hazard query
  logic            id_valid;
  logic            id_rd_req;
  logic [AW-1:0]   id_rd_addr;
  // long-latency scoreboard
  logic            sb_set;
  logic [AW-1:0]   sb_set_addr;
  logic            sb_clr;
  logic [AW-1:0]   sb_clr_addr;
  logic            flush;
  // status
  logic            busy_stall;
  logic [AW:0]     pend_cnt;
  logic            sb_err;

  modport master (
    output rf_raddr1, rf_raddr2, wb_we, wb_waddr, wb_wdata,
           id_valid, id_rd_req, id_rd_addr,
           sb_set, sb_set_addr, sb_clr, sb_clr_addr, flush,
    input  rf_rdata1, rf_rdata2, busy_stall, pend_cnt, sb_err
  );

  modport slave (
    input  rf_raddr1, rf_raddr2, wb_we, wb_waddr, wb_wdata,
           id_valid, id_rd_req, id_rd_addr,
           sb_set, sb_set_addr, sb_clr, sb_clr_addr, flush,
    output rf_rdata1, rf_rdata2, busy_stall, pend_cnt, sb_err
  );
endinterface

// File: rtl/gpr_file.sv
// Integer register file (x1..x(2^AW-1), x0 hardwired to zero) with a
// pending-result scoreboard for long-latency mul/div producers.
// Each architectural register is one gpr_cell holding its data word and
// its busy bit; the top does the read muxing, hazard stall, pending count
// and protocol-error tracking.

// One register: storage word plus its scoreboard busy bit.
module gpr_cell #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int IDX  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            flush,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_set_addr,
  input  logic            sb_clr,
  input  logic [AW-1:0]   sb_clr_addr,
  output logic [XLEN-1:0] q,
  output logic            busy,
  output logic            busy_nxt,
  output logic            busy_eff
);
  localparam logic [AW-1:0] A = AW'(IDX);

  logic wr_hit, set_hit, clr_hit;

  assign wr_hit  = wb_we  && (wb_waddr    == A);
  assign set_hit = sb_set && (sb_set_addr == A);
  assign clr_hit = sb_clr && (sb_clr_addr == A);

  // Data word: capture writeback, independent of any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (wr_hit) q <= wb_wdata;
  end

  // Busy next state: flush kills everything (including a same-cycle issue),
  // then a new producer beats a completing one on the same register.
  always_comb begin
    busy_nxt = busy;
    if (flush)        busy_nxt = 1'b0;
    else if (set_hit) busy_nxt = 1'b1;
    else if (clr_hit) busy_nxt = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= busy_nxt;
  end

  // A result completing this cycle no longer blocks decode; the read bypass
  // supplies its value.
  assign busy_eff = busy & ~clr_hit;
endmodule

module gpr_file #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input logic     clk,
  input logic     rst,
  gpr_file_if.slave rf
);
  localparam int NREG = 1 << AW;
  localparam int CW   = AW + 1;

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, busy_nxt, busy_eff;
  logic [CW-1:0]             cnt_nxt, pend_q;
  logic                      err_q, clr_idle, set_dup;

  // x0 is not stored and never pending.
  assign regs[0]     = '0;
  assign busy[0]     = 1'b0;
  assign busy_nxt[0] = 1'b0;
  assign busy_eff[0] = 1'b0;

  genvar g;
  for (g = 1; g < NREG; g++) begin : g_cell
    gpr_cell #(.XLEN(XLEN), .AW(AW), .IDX(g)) u_cell (
      .clk        (clk),
      .rst        (rst),
      .wb_we      (rf.wb_we),
      .wb_waddr   (rf.wb_waddr),
      .wb_wdata   (rf.wb_wdata),
      .flush      (rf.flush),
      .sb_set     (rf.sb_set),
      .sb_set_addr(rf.sb_set_addr),
      .sb_clr     (rf.sb_clr),
      .sb_clr_addr(rf.sb_clr_addr),
      .q          (regs[g]),
      .busy       (busy[g]),
      .busy_nxt   (busy_nxt[g]),
      .busy_eff   (busy_eff[g])
    );
  end

  // Read ports: x0 -> 0, then same-cycle writeback bypass, then storage.
  always_comb begin
    rf.rf_rdata1 = regs[rf.rf_raddr1];
    if (rf.rf_raddr1 == '0)
      rf.rf_rdata1 = '0;
    else if (rf.wb_we && rf.wb_waddr == rf.rf_raddr1)
      rf.rf_rdata1 = rf.wb_wdata;

    rf.rf_rdata2 = regs[rf.rf_raddr2];
    if (rf.rf_raddr2 == '0)
      rf.rf_rdata2 = '0;
    else if (rf.wb_we && rf.wb_waddr == rf.rf_raddr2)
      rf.rf_rdata2 = rf.wb_wdata;
  end

  // RAW on either source or WAW on rd against an outstanding long-latency result.
  assign rf.busy_stall = rf.id_valid &
                         (busy_eff[rf.rf_raddr1] | busy_eff[rf.rf_raddr2] |
                          (rf.id_rd_req & busy_eff[rf.id_rd_addr]));

  // Popcount of the next busy vector, so the registered count tracks busy.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < NREG; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  // Pending-register count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= cnt_nxt;
  end

  // Protocol violations: completing something never issued, or re-issuing to
  // a register whose previous producer is still outstanding.
  assign clr_idle = rf.sb_clr && (rf.sb_clr_addr != '0) && !busy[rf.sb_clr_addr];
  assign set_dup  = rf.sb_set && (rf.sb_set_addr != '0) && busy[rf.sb_set_addr] &&
                    !(rf.sb_clr && rf.sb_clr_addr == rf.sb_set_addr);

  // Sticky error flag, cleared only by reset; flushes are exempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     err_q <= 1'b0;
    else if (!rf.flush && (clr_idle || set_dup)) err_q <= 1'b1;
  end

  assign rf.pend_cnt = pend_q;
  assign rf.sb_err   = err_q;
endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- Integer register file with a long-latency result scoreboard.
- Serves the two combinational read ports that the decode stage consumes, and takes the single writeback port from WB.
- Tracks registers that have an outstanding mul/div result. Raises a decode stall on RAW or WAW hazards against those registers.
- Sits between WB (writer) and ID (reader); decode-stage EX/MEM forwarding stays outside this block.

Parameters:
- XLEN, 64, register data width.
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- rf_raddr1  in  AW  read port 1 address
- rf_rdata1  out  XLEN  read port 1 data (combinational)
- rf_raddr2  in  AW  read port 2 address
- rf_rdata2  out  XLEN  read port 2 data (combinational)
- wb_we  in  1  writeback write enable
- wb_waddr  in  AW  writeback destination
- wb_wdata  in  XLEN  writeback data
- id_valid  in  1  decode slot holds a valid instruction
- id_rd_req  in  1  decode instruction writes rd
- id_rd_addr  in  AW  decode instruction rd
- sb_set  in  1  mul/div issued to EX this cycle; mark rd pending
- sb_set_addr  in  AW  rd of issued mul/div
- sb_clr  in  1  mul/div result written back this cycle
- sb_clr_addr  in  AW  rd of completing mul/div
- flush  in  1  pipeline flush (trap/mret/branch kill); drops all pending marks
- busy_stall  out  1  decode must hold (combinational)
- pend_cnt  out  6  number of pending registers (registered)
- sb_err  out  1  sticky scoreboard protocol error

Behaviour:
- Reset (asynchronous, rst=1):
  - All 31 registers x1..x31 cleared to 0.
  - busy[31:1] cleared; pend_cnt=0; sb_err=0.
  - Outputs valid during reset: rdata = 0 unless bypassed, busy_stall=0.
- x0:
  - Not stored; always reads 0.
  - Writes to x0 are dropped.
  - sb_set/sb_clr with address 0 are ignored and do not raise sb_err.
- Write:
  - On posedge clk, if wb_we=1 and wb_waddr!=0, regs[wb_waddr] <= wb_wdata.
  - Latency: 1 cycle to storage.
- Read (zero latency, combinational):
  - raddr==0 -> 0.
  - Otherwise, if wb_we and wb_waddr==raddr -> wb_wdata (same-cycle write-through bypass).
  - Otherwise -> regs[raddr].
  - Both ports are independent and may hit the same address.
- Scoreboard next state, per address a!=0, in priority order:
  1. flush=1 -> busy[a]<=0 for all a. A same-cycle sb_set is dropped (the issuing instruction is killed).
  2. sb_set and sb_set_addr==a -> busy[a]<=1. Set wins over a same-cycle clear of the same address, because the new producer remains outstanding.
  3. sb_clr and sb_clr_addr==a -> busy[a]<=0.
  4. Otherwise hold.
- Effective busy: busy_eff[a] = busy[a] & ~(sb_clr & sb_clr_addr==a). A completing result unblocks decode in the same cycle; the bypass supplies its data.
- busy_stall = id_valid & ( busy_eff[rf_raddr1] | busy_eff[rf_raddr2] | (id_rd_req & busy_eff[id_rd_addr]) ).
  - Index 0 never contributes.
  - Decode is responsible for driving raddr=0 for unused sources.
- pend_cnt:
  - Registered popcount of next busy; range 0..31.
  - Updated with busy; no wrap is possible.
- sb_err is set, and held until reset, when either of these occurs without flush:
  - sb_clr to an address whose busy bit is 0.
  - sb_set to an address already busy and not cleared that same cycle.
  - sb_err has no effect on datapath behaviour.
- No clock enable: storage always updates on a valid write, including during busy_stall.

Test Plan:
- Reset mid-run: write x5=0x1234, assert rst asynchronously between edges -> rf_rdata1(raddr1=5)=0 immediately; pend_cnt=0; sb_err=0.
- x0 and bypass:
  - wb_we=1, waddr=0, wdata=0xFFFF -> read x0 gives 0.
  - wb_we=1, waddr=7, wdata=0xABCD with raddr1=raddr2=7 in the same cycle -> both ports 0xABCD that cycle and from storage next cycle.
- RAW stall:
  - sb_set x10 -> next cycle id_valid=1, raddr2=10 -> busy_stall=1; pend_cnt=1.
  - sb_clr x10 with wb_we x10=0x55 -> busy_stall=0 that cycle and rf_rdata2=0x55; pend_cnt=0 next cycle.
- WAW and set/clr collision:
  - x3 busy; decode id_rd_req=1, rd=3, sources x0 -> busy_stall=1.
  - Same-cycle sb_clr x3 and sb_set x3 -> busy[3] stays 1, no sb_err.
- Flush: set x4, x8, x9 (pend_cnt=3); flush=1 together with sb_set x12 -> next cycle pend_cnt=0, busy_stall=0 for all sources.
- Protocol error: sb_clr x6 while idle -> sb_err=1 next cycle and stays 1 through further traffic until rst.
